// File: rtl/ota_density_decimator_if.sv
// Result stream of the density decimator: one-deep valid/ready register carrying
// the ones-density and filtered-edge count of the last completed window.
interface ota_density_decimator_if #(
  parameter int WIN_LOG2 = 6
);
  logic [WIN_LOG2:0] density;
  logic [7:0]        edges;
  logic              density_valid;
  logic              density_ready;

  modport master (
    output density, edges, density_valid,
    input  density_ready
  );

  modport slave (
    input  density, edges, density_valid,
    output density_ready
  );
endinterface

// File: rtl/ota_density_decimator.sv
// Comparator back end: 2-flop sync + FILT_LEN glitch filter (2+FILT_LEN clocks), then per-window ones/edge integration.
// Results sit in a one-deep register; a load over an unconsumed result overwrites it and sets sticky overrun.
module ota_density_decimator #(
  parameter int WIN_LOG2 = 6,
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cmp_in_i,
  input  logic en_i,
  output logic cmp_filt_o,
  output logic overrun_o,
  output logic busy_o,
  ota_density_decimator_if.master res_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_e;

  localparam logic [3:0]          SETTLE_LAST = 4'(FILT_LEN + 1);
  localparam logic [WIN_LOG2-1:0] PHASE_LAST  = '1;

  state_e              state_q, state_d;
  logic                s1_q, s2_q;
  logic [FILT_LEN-1:0] win;
  logic                filt_q, filt_d, filt_prev_q;
  logic [3:0]          settle_q, settle_d;
  logic [WIN_LOG2-1:0] phase_q, phase_d;
  logic [WIN_LOG2:0]   ones_q, ones_d, ones_sum;
  logic [7:0]          edg_q, edg_d, edg_sum;
  logic [WIN_LOG2:0]   dens_q, dens_d;
  logic [7:0]          edges_q, edges_d;
  logic                vld_q, vld_d, ovr_q, ovr_d;

  // The newest of the FILT_LEN filter samples is s2 itself, so only FILT_LEN-1 older ones are stored.
  if (FILT_LEN > 1) begin : g_hist
    logic [FILT_LEN-2:0] old_q;
    assign win = {old_q, s2_q};
    always_ff @(posedge clk) begin
      if (rst) old_q <= '0;
      else     old_q <= win[FILT_LEN-2:0];
    end
  end else begin : g_nohist
    assign win = s2_q;
  end

  always_comb begin
    filt_d = filt_q;
    if (&win)       filt_d = 1'b1;
    else if (~|win) filt_d = 1'b0;
  end

  assign ones_sum = ones_q + (WIN_LOG2 + 1)'(filt_q);
  assign edg_sum  = (filt_q != filt_prev_q && edg_q != 8'hFF) ? edg_q + 8'd1 : edg_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    phase_d  = phase_q;
    ones_d   = ones_q;
    edg_d    = edg_q;
    dens_d   = dens_q;
    edges_d  = edges_q;
    vld_d    = vld_q && !res_o.density_ready;
    ovr_d    = ovr_q;
    if (!en_i) begin
      state_d  = IDLE;
      settle_d = '0;
      phase_d  = '0;
      ones_d   = '0;
      edg_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = ACCUM;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        ACCUM: begin
          phase_d = phase_q + WIN_LOG2'(1);
          ones_d  = ones_sum;
          edg_d   = edg_sum;
          if (phase_q == PHASE_LAST) begin
            dens_d  = ones_sum;
            edges_d = edg_sum;
            ones_d  = '0;
            edg_d   = '0;
            ovr_d   = ovr_q | (vld_q & ~res_o.density_ready);
            vld_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      settle_q    <= '0;
      phase_q     <= '0;
      ones_q      <= '0;
      edg_q       <= '0;
      dens_q      <= '0;
      edges_q     <= '0;
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= cmp_in_i;
      s2_q        <= s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      settle_q    <= settle_d;
      phase_q     <= phase_d;
      ones_q      <= ones_d;
      edg_q       <= edg_d;
      dens_q      <= dens_d;
      edges_q     <= edges_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
    end
  end

  assign cmp_filt_o          = filt_q;
  assign busy_o              = (state_q != IDLE);
  assign overrun_o           = ovr_q;
  assign res_o.density       = dens_q;
  assign res_o.edges         = edges_q;
  assign res_o.density_valid = vld_q;
endmodule

// File: tb/tb_ota_density_decimator.sv
// Randomized bench for ota_density_decimator with a cycle-stepped behavioural model.
module tb_ota_density_decimator;
  localparam int W   = 6;
  localparam int F   = 3;
  localparam int WIN = 1 << W;
  localparam int LIM = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_in = 1'b0;
  logic en = 1'b0;
  logic cmp_filt, overrun, busy;

  always #5 clk = ~clk;

  ota_density_decimator_if #(.WIN_LOG2(W)) res_if ();

  ota_density_decimator #(.WIN_LOG2(W), .FILT_LEN(F)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmp_in_i   (cmp_in),
    .en_i       (en),
    .cmp_filt_o (cmp_filt),
    .overrun_o  (overrun),
    .busy_o     (busy),
    .res_o      (res_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: cmp_in samples per edge; filtered level from the rule on delayed samples;
  // windows placed by counting consecutive enabled edges.
  bit smp_q[$];
  bit m_filt, m_fprev, m_dv, m_ovr;
  int m_run, m_ones, m_edg, m_dens, m_edges, m_loads;

  task automatic model_step(input bit c, input bit e, input bit r, input bit rs);
    bit fb, fbb, loaded, same;
    int pos;
    if (rs) begin
      smp_q.delete();
      repeat (F + 2) smp_q.push_back(1'b0);
      m_filt = 0; m_fprev = 0; m_run = 0; m_ones = 0; m_edg = 0;
      m_dens = 0; m_edges = 0; m_dv = 0; m_ovr = 0;
      return;
    end
    fb = m_filt;
    fbb = m_fprev;
    loaded = 0;
    if (e) begin
      m_run++;
      if (m_run >= F + 4) begin
        pos = (m_run - F - 4) % WIN;
        m_ones += int'(fb);
        if (fb != fbb && m_edg < 255) m_edg++;
        if (pos == WIN - 1) begin
          if (m_dv && !r) m_ovr = 1;
          m_dens = m_ones; m_edges = m_edg; m_dv = 1; loaded = 1; m_loads++;
          m_ones = 0; m_edg = 0;
        end
      end
    end else begin
      m_run = 0; m_ones = 0; m_edg = 0;
    end
    if (!loaded && r) m_dv = 0;
    smp_q.push_back(c);
    void'(smp_q.pop_front());
    same = 1;
    for (int i = 1; i < F; i++) if (smp_q[i] != smp_q[0]) same = 0;
    m_fprev = m_filt;
    if (same) m_filt = smp_q[0];
  endtask

  function automatic int next_pos();
    int r;
    r = m_run + 1;
    return (r >= F + 4) ? (r - F - 4) % WIN : -1;
  endfunction

  task automatic tick(input bit c, input bit e, input bit r, input bit rs);
    cmp_in = c;
    en = e;
    res_if.density_ready = r;
    rst = rs;
    @(posedge clk);
    model_step(c, e, r, rs);
    #1;
  endtask

  task automatic test_reset();
    bit c;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      n_vec++;
      if ({cmp_filt, busy, res_if.density_valid, overrun, res_if.density, res_if.edges} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs got=%b/%b/%b/%b/%0d/%0d exp=all 0", cmp_filt, busy,
                 res_if.density_valid, overrun, res_if.density, res_if.edges);
      end
    end
    for (int i = 0; i < 8; i++) begin
      c = 1'($urandom);
      tick(c, 1'b0, 1'($urandom), 1'b0);
      n_vec++;
      if ({busy, res_if.density_valid, cmp_filt} !== {1'b0, 1'b0, m_filt}) begin
        n_err++;
        $display("FAIL idle_hold got busy=%b vld=%b filt=%b exp 0 0 %b", busy,
                 res_if.density_valid, cmp_filt, m_filt);
      end
    end
  endtask

  task automatic test_const_high();
    int res = 0;
    for (int t = 0; t < LIM && res < 3; t++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if ({cmp_filt, busy, res_if.density_valid, overrun} !== {m_filt, m_run > 0, m_dv, m_ovr}) begin
        n_err++;
        $display("FAIL const_ctrl got=%b%b%b%b exp=%b%b%b%b", cmp_filt, busy, res_if.density_valid,
                 overrun, m_filt, m_run > 0, m_dv, m_ovr);
      end
      if (res_if.density_valid) begin
        res++;
        n_vec++;
        if (res_if.density !== 7'(WIN) || res_if.edges !== 8'(m_edges) ||
            (res > 1 && res_if.edges !== 8'd0)) begin
          n_err++;
          $display("FAIL const_window%0d got=%0d/%0d exp=%0d/%0d", res, res_if.density,
                   res_if.edges, WIN, (res > 1) ? 0 : m_edges);
        end
      end
    end
    n_vec++;
    if (res < 3) begin
      n_err++;
      $display("FAIL const_timeout got=%0d results exp=3", res);
    end
  endtask

  task automatic test_square();
    int res = 0;
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      tick(bit'((k % 8) < 4), 1'b0, 1'b1, 1'b0);
      k++;
    end
    for (int t = 0; t < LIM && res < 3; t++) begin
      tick(bit'((k % 8) < 4), 1'b1, 1'b1, 1'b0);
      k++;
      n_vec++;
      if (cmp_filt !== m_filt) begin
        n_err++;
        $display("FAIL square_filt got=%b exp=%b", cmp_filt, m_filt);
      end
      if (res_if.density_valid) begin
        res++;
        n_vec++;
        if (res_if.density !== 7'd32 || res_if.edges !== 8'd16 ||
            res_if.density !== 7'(m_dens) || res_if.edges !== 8'(m_edges)) begin
          n_err++;
          $display("FAIL square_window%0d got=%0d/%0d exp=32/16 model=%0d/%0d", res,
                   res_if.density, res_if.edges, m_dens, m_edges);
        end
      end
    end
    n_vec++;
    if (res < 3) begin
      n_err++;
      $display("FAIL square_timeout got=%0d results exp=3", res);
    end
  endtask

  task automatic test_glitch();
    int res = 0;
    int k = 0;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int t = 0; t < LIM && res < 2; t++) begin
      tick(bit'((k % 20) == 0 || (k % 20) == 10 || (k % 20) == 11), 1'b1, 1'b1, 1'b0);
      k++;
      n_vec++;
      if (cmp_filt !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_filt got=%b exp=0", cmp_filt);
      end
      if (res_if.density_valid) begin
        res++;
        n_vec++;
        if (res_if.density !== '0 || res_if.edges !== '0) begin
          n_err++;
          $display("FAIL glitch_window%0d got=%0d/%0d exp=0/0", res, res_if.density, res_if.edges);
        end
      end
    end
    n_vec++;
    if (res < 2) begin
      n_err++;
      $display("FAIL glitch_timeout got=%0d results exp=2", res);
    end
  endtask

  task automatic test_back_to_back();
    bit c = 0;
    int t = 0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    while (!res_if.density_valid && t < LIM) begin
      if ($urandom_range(0, 5) == 0) c = ~c;
      tick(c, 1'b1, 1'b0, 1'b0);
      t++;
    end
    while (next_pos() != WIN - 1 && t < LIM) begin
      if ($urandom_range(0, 5) == 0) c = ~c;
      tick(c, 1'b1, 1'b0, 1'b0);
      t++;
    end
    n_vec++;
    if (t >= LIM) begin
      n_err++;
      $display("FAIL b2b_timeout got=%0d cycles exp<%0d", t, LIM);
    end
    tick(c, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (res_if.density_valid !== 1'b1 || overrun !== 1'b0 ||
        res_if.density !== 7'(m_dens) || res_if.edges !== 8'(m_edges)) begin
      n_err++;
      $display("FAIL b2b_load_consume got vld=%b ovr=%b %0d/%0d exp vld=1 ovr=0 %0d/%0d",
               res_if.density_valid, overrun, res_if.density, res_if.edges, m_dens, m_edges);
    end
    tick(c, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (res_if.density_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got vld=%b exp=0", res_if.density_valid);
    end
  endtask

  task automatic test_backpressure();
    bit c = 0;
    int t = 0;
    int start = m_loads;
    int d2, e2;
    while (m_loads < start + 2 && t < LIM) begin
      if ($urandom_range(0, 4) == 0) c = ~c;
      tick(c, 1'b1, 1'b0, 1'b0);
      t++;
    end
    d2 = m_dens;
    e2 = m_edges;
    n_vec++;
    if (overrun !== 1'b1 || res_if.density_valid !== 1'b1 ||
        res_if.density !== 7'(d2) || res_if.edges !== 8'(e2)) begin
      n_err++;
      $display("FAIL bp_overrun got ovr=%b vld=%b %0d/%0d exp ovr=1 vld=1 %0d/%0d", overrun,
               res_if.density_valid, res_if.density, res_if.edges, d2, e2);
    end
    tick(c, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (res_if.density_valid !== 1'b0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release got vld=%b ovr=%b exp vld=0 ovr=1", res_if.density_valid, overrun);
    end
  endtask

  task automatic test_abort();
    bit c = 0;
    int t = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    while (next_pos() != 30 && t < LIM) begin
      if ($urandom_range(0, 3) == 0) c = ~c;
      tick(c, 1'b1, 1'b1, 1'b0);
      t++;
    end
    tick(c, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (busy !== 1'b0 || res_if.density_valid !== 1'b0 || t >= LIM) begin
      n_err++;
      $display("FAIL abort_drop got busy=%b vld=%b cycles=%0d exp busy=0 vld=0", busy,
               res_if.density_valid, t);
    end
    for (int i = 0; i < 5; i++) begin
      tick(c, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (res_if.density_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle got vld=%b busy=%b exp 0 0", res_if.density_valid, busy);
      end
    end
    t = 0;
    do begin
      if ($urandom_range(0, 3) == 0) c = ~c;
      tick(c, 1'b1, 1'b1, 1'b0);
      t++;
    end while (!res_if.density_valid && t < LIM);
    n_vec++;
    if (t - 1 != F + 2 + WIN || res_if.density !== 7'(m_dens) || res_if.edges !== 8'(m_edges)) begin
      n_err++;
      $display("FAIL abort_reenable got lat=%0d %0d/%0d exp lat=%0d %0d/%0d", t - 1,
               res_if.density, res_if.edges, F + 2 + WIN, m_dens, m_edges);
    end
  endtask

  initial begin
    res_if.density_ready = 1'b0;
    test_reset();
    test_const_high();
    test_square();
    test_glitch();
    test_back_to_back();
    test_backpressure();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ota_density_decimator.md
# ota_density_decimator

Digital back end for the digit OTA comparator. Samples the comparator's 1-bit output `Out`, synchronizes and glitch-filters it, and integrates it over fixed windows of 2^WIN_LOG2 clocks. Each window produces a ones-density word and a transition count through a one-deep valid/ready output register, and overruns are flagged. Sits directly downstream of the OTA cell and feeds the readout logic on `uo_out`/`uio_out`.

## Interface
- `WIN_LOG2`, 6: log2 of the window length in clocks (window = 64 by default). Range 2..12.
- `FILT_LEN`, 3: number of consecutive equal synchronized samples required to change the filtered level. Range 1..8.
- `clk` input 1: single clock. Everything is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `cmp_in` input 1: raw comparator output. Asynchronous to `clk`.
- `en` input 1: run enable. Low forces IDLE and discards any partial window.
- `cmp_filt` output 1: filtered comparator level.
- `density` output WIN_LOG2+1: count of filtered-high cycles in the last completed window (0..2^WIN_LOG2).
- `edges` output 8: transitions of the filtered level in the last completed window, saturating at 255.
- `density_valid` output 1: result register holds an unconsumed result.
- `density_ready` input 1: consumer accepts the result when `density_valid && density_ready`.
- `overrun` output 1: sticky flag. Set when an unconsumed result is overwritten.
- `busy` output 1: high in SETTLE or ACCUM.

## Operation
- Synchronizer: two flops, `s1 <= cmp_in`, `s2 <= s1`. Both reset to 0.
- Glitch filter:
  - Keeps a shift history of the last FILT_LEN values of `s2`, reset to 0.
  - `cmp_filt` takes the new value once all FILT_LEN history entries equal it and differ from the current `cmp_filt`. Otherwise it holds.
  - Pulses shorter than FILT_LEN cycles never reach `cmp_filt`.
  - The synchronizer and filter run in every state except reset.
- FSM states:
  - IDLE: counters held at 0. Go to SETTLE when `en` = 1.
  - SETTLE: wait FILT_LEN+2 cycles so the pipeline flushes, then go to ACCUM.
  - ACCUM: window phase counter runs 0..2^WIN_LOG2−1. The cycle at phase 2^WIN_LOG2−1 is the final one; the next window starts immediately at phase 0 with no gap cycles.
  - In any state, `en` = 0 returns to IDLE on the next edge. Phase, accumulators and partial results are cleared. The result register, `density_valid` and `overrun` are untouched.
- Accumulation, on each ACCUM cycle:
  - The ones accumulator adds `cmp_filt`. Width is WIN_LOG2+1, so a window of all ones gives exactly 2^WIN_LOG2 with no wrap.
  - The edge accumulator increments when `cmp_filt` differs from its value on the previous clock. That previous value may come from SETTLE or from the prior window. The edge accumulator saturates at 255.
- Window end, on the final ACCUM cycle, including that cycle's contribution:
  - Load `density`/`edges` from the accumulators.
  - Set `density_valid`.
  - Clear the accumulators for the next window.
- Output handshake:
  - `density_valid` clears after a cycle with `density_valid && density_ready`, unless a load happens in the same cycle. In that case it stays 1 with the new data, and this is not an overrun.
  - A load while `density_valid && !density_ready` overwrites the data and sets `overrun`.
  - `overrun` clears only on `rst`.

## Timing
- Reset values: `cmp_filt`, `density`, `edges`, `density_valid`, `overrun` and `busy` are all 0. FSM starts in IDLE.
- Latency from a `cmp_in` change to `cmp_filt` is 2 + FILT_LEN clocks: 5 with the defaults.
- `busy` rises on the first edge where `en` = 1 is sampled.
- With `en` held high from that edge, the first window occupies clocks FILT_LEN+3 .. FILT_LEN+2+2^WIN_LOG2 after it.
- `density_valid` rises one clock after the final window cycle. After that, a result arrives every 2^WIN_LOG2 clocks.
- `rst` mid-window:
  - All state returns to reset values on that edge, including the result register.
  - No result is emitted for the partial window.

## Test plan
- Reset: assert `rst` for 3 clocks with random inputs. All outputs must be 0, and IDLE must hold while `en` = 0.
- Constant high: `cmp_in` = 1, `en` = 1, `density_ready` = 1. First `density_valid` pulse must show `density` = 64, `edges` = 1 (the initial 0→1 rise, if it lands in the window; otherwise 0, so check against the model). Every later window must give 64 and 0.
- Square wave, 4 clocks high / 4 low, steady: every window must give `density` = 32 and `edges` = 16.
- Glitch rejection: `cmp_in` = 0 with 1-clock and 2-clock high pulses every 10 clocks. `cmp_filt` must stay 0, and every window must give 0 and 0.
- Backpressure: `density_ready` = 0 across two window ends. `overrun` must be 1 and the data must equal the second window. Raising `density_ready` must clear `density_valid` with `overrun` staying 1. Also check a load in the same cycle as a consume: `density_valid` stays 1, `overrun` stays 0.
- Abort: drop `en` at phase 30 of a window. `busy` must go 0 on the next edge with no new result. Re-enabling must repeat SETTLE, and the first result must arrive FILT_LEN+2+64 clocks later.
